// File: rtl/ecc_secded_dec_pipe.sv
// ecc_secded_dec_pipe: two-stage SECDED Hamming decoder for NoC receive flits.
// Stage 1 computes the syndrome; stage 2 classifies, corrects, and counts errors.
module ecc_secded_dec_pipe #(
    parameter int DATA_W = 32,
    parameter int CHK_W  = 8,
    parameter int CNT_W  = 16
) (
    input  logic                       i_aclk,
    input  logic                       i_aresetn,
    input  logic                       i_enable_ecc,
    input  logic                       i_valid,
    output logic                       o_ready,
    input  logic [DATA_W+CHK_W-1:0]    i_codeword,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [DATA_W-1:0]          o_data,
    output logic                       o_serr,
    output logic                       o_derr,
    output logic [CHK_W-1:0]           o_syndrome,
    input  logic                       i_cnt_clr,
    output logic [CNT_W-1:0]           o_serr_cnt,
    output logic [CNT_W-1:0]           o_derr_cnt
);
    localparam int CW_W = DATA_W + CHK_W;
    localparam int HW   = CHK_W - 1;
    localparam logic [HW-1:0]    S_MAX   = HW'(CW_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Position of data bit idx: the idx-th non-power-of-two position.
    function automatic int data_pos(input int idx);
        int cnt;
        int res;
        cnt = 0;
        res = 0;
        for (int p = 1; p < 2 * CW_W + 2; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (cnt == idx) res = p;
                cnt++;
            end
        end
        return res;
    endfunction

    // Data bits covered by Hamming bit k.
    function automatic logic [DATA_W-1:0] ham_mask(input int k);
        logic [DATA_W-1:0] m;
        m = '0;
        for (int i = 0; i < DATA_W; i++) begin
            m[i] = ((data_pos(i) >> k) & 1) != 0;
        end
        return m;
    endfunction

    logic                 advance;
    logic [DATA_W-1:0]    in_data;
    logic [HW-1:0]        in_chk;
    logic [HW-1:0]        h_calc;
    logic [CHK_W-1:0]     syn_in;

    logic                 s1_valid;
    logic                 s1_byp;
    logic [DATA_W-1:0]    s1_data;
    logic [CHK_W-1:0]     s1_syn;

    logic                 s1_p;
    logic [HW-1:0]        s1_s;
    logic [DATA_W-1:0]    flip;
    logic                 hit;
    logic                 s_zero;
    logic                 s_pow2;
    logic                 fixable;
    logic                 c_serr;
    logic                 c_derr;
    logic [DATA_W-1:0]    c_data;
    logic                 out_hs;

    assign advance = i_ready | ~o_valid;
    assign o_ready = advance;
    assign out_hs  = o_valid & i_ready;

    assign in_data = i_codeword[DATA_W-1:0];
    assign in_chk  = i_codeword[DATA_W +: HW];
    assign syn_in  = {^i_codeword, h_calc ^ in_chk};

    for (genvar k = 0; k < HW; k++) begin : g_ham
        localparam logic [DATA_W-1:0] MASK = ham_mask(k);
        assign h_calc[k] = ^(in_data & MASK);
    end

    assign s1_p = s1_syn[HW];
    assign s1_s = s1_syn[HW-1:0];

    for (genvar i = 0; i < DATA_W; i++) begin : g_flip
        localparam int POS = data_pos(i);
        assign flip[i] = (s1_s == HW'(POS));
    end

    // Classify the stage-1 syndrome and build the corrected word.
    always_comb begin
        hit     = |flip;
        s_zero  = (s1_s == '0);
        s_pow2  = !s_zero && ((s1_s & (s1_s - HW'(1))) == '0);
        fixable = s_zero | (s_pow2 & (s1_s <= S_MAX)) | hit;
        c_serr  = ~s1_byp & s1_p & fixable;
        c_derr  = ~s1_byp & ((s1_p & ~fixable) | (~s1_p & ~s_zero));
        c_data  = s1_data;
        if (~s1_byp & s1_p & hit) c_data = s1_data ^ flip;
    end

    // Stage 1: capture data, syndrome and bypass flag on advance.
    always_ff @(posedge i_aclk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            s1_valid <= 1'b0;
            s1_byp   <= 1'b0;
            s1_data  <= '0;
            s1_syn   <= '0;
        end else if (advance) begin
            s1_valid <= i_valid;
            if (i_valid) begin
                s1_byp  <= ~i_enable_ecc;
                s1_data <= in_data;
                s1_syn  <= syn_in;
            end
        end
    end

    // Stage 2: register the classified, corrected output word.
    always_ff @(posedge i_aclk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            o_valid    <= 1'b0;
            o_data     <= '0;
            o_serr     <= 1'b0;
            o_derr     <= 1'b0;
            o_syndrome <= '0;
        end else if (advance) begin
            o_valid <= s1_valid;
            if (s1_valid) begin
                o_data     <= c_data;
                o_serr     <= c_serr;
                o_derr     <= c_derr;
                o_syndrome <= s1_byp ? '0 : s1_syn;
            end else begin
                o_serr <= 1'b0;
                o_derr <= 1'b0;
            end
        end
    end

    // Saturating error counters; clear wins over a coincident increment.
    always_ff @(posedge i_aclk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            o_serr_cnt <= '0;
            o_derr_cnt <= '0;
        end else if (i_cnt_clr) begin
            o_serr_cnt <= '0;
            o_derr_cnt <= '0;
        end else if (out_hs) begin
            if (o_serr && o_serr_cnt != CNT_MAX) o_serr_cnt <= o_serr_cnt + 1'b1;
            if (o_derr && o_derr_cnt != CNT_MAX) o_derr_cnt <= o_derr_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_ecc_secded_dec_pipe.sv
// tb_ecc_secded_dec_pipe: scoreboard bench for the SECDED decoder pipe.
// Expected words come from a position-XOR reference model of SECDED.
module tb_ecc_secded_dec_pipe;

    typedef struct packed {
        logic [31:0] d;
        logic        serr;
        logic        derr;
        logic [7:0]  syn;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        i_valid;
    logic        o_ready;
    logic [39:0] i_codeword;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_data;
    logic        o_serr;
    logic        o_derr;
    logic [7:0]  o_syndrome;
    logic        i_cnt_clr;
    logic [3:0]  o_serr_cnt;
    logic [3:0]  o_derr_cnt;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_out = 0;
    int   pos_tab[32];
    exp_t q[$];
    exp_t e_pop;
    bit   mon_on = 0;
    int   m_serr = 0;
    int   m_derr = 0;
    bit   hs_s;
    bit   hs_d;
    logic [31:0] last_data;
    logic        last_serr;
    logic        last_derr;
    logic [7:0]  last_syn;

    ecc_secded_dec_pipe #(.DATA_W(32), .CHK_W(8), .CNT_W(4)) dut (
        .i_aclk      (clk),
        .i_aresetn   (rst_n),
        .i_enable_ecc(en),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_codeword  (i_codeword),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_data      (o_data),
        .o_serr      (o_serr),
        .o_derr      (o_derr),
        .o_syndrome  (o_syndrome),
        .i_cnt_clr   (i_cnt_clr),
        .o_serr_cnt  (o_serr_cnt),
        .o_derr_cnt  (o_derr_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [39:0] encode(input logic [31:0] d);
        logic [39:0] cw;
        int s;
        s = 0;
        for (int i = 0; i < 32; i++) if (d[i]) s ^= pos_tab[i];
        cw = '0;
        cw[31:0]  = d;
        cw[38:32] = 7'(s);
        cw[39]    = ^cw[38:0];
        return cw;
    endfunction

    function automatic exp_t ref_dec(input logic [39:0] cw, input logic e);
        exp_t r;
        int s;
        int fix;
        logic p;
        r.d = cw[31:0];
        r.serr = 1'b0;
        r.derr = 1'b0;
        r.syn = 8'h00;
        if (!e) return r;
        s = 0;
        for (int i = 0; i < 32; i++) if (cw[i]) s ^= pos_tab[i];
        for (int k = 0; k < 7; k++) if (cw[32+k]) s ^= (1 << k);
        p = ^cw;
        r.syn = {p, 7'(s)};
        if (!p) begin
            r.derr = (s != 0);
        end else if (s == 0 || (((s & (s - 1)) == 0) && s <= 39)) begin
            r.serr = 1'b1;
        end else begin
            fix = -1;
            for (int i = 0; i < 32; i++) if (pos_tab[i] == s) fix = i;
            if (fix >= 0) begin
                r.d[fix] = ~r.d[fix];
                r.serr = 1'b1;
            end else begin
                r.derr = 1'b1;
            end
        end
        return r;
    endfunction

    // Monitor: counters, output scoreboard, then counter model update.
    always @(negedge clk) begin
        if (rst_n && mon_on) begin
            hs_s = 0;
            hs_d = 0;
            chk("serr_cnt", 64'(o_serr_cnt), 64'(m_serr));
            chk("derr_cnt", 64'(o_derr_cnt), 64'(m_derr));
            if (o_valid && i_ready) begin
                n_out++;
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_output: got data %h, none expected", o_data);
                end else begin
                    e_pop = q.pop_front();
                    chk("data", 64'(o_data), 64'(e_pop.d));
                    chk("serr", 64'(o_serr), 64'(e_pop.serr));
                    chk("derr", 64'(o_derr), 64'(e_pop.derr));
                    chk("syndrome", 64'(o_syndrome), 64'(e_pop.syn));
                    last_data = o_data;
                    last_serr = o_serr;
                    last_derr = o_derr;
                    last_syn  = o_syndrome;
                    hs_s = e_pop.serr;
                    hs_d = e_pop.derr;
                end
            end
            if (i_valid && o_ready) q.push_back(ref_dec(i_codeword, en));
            if (i_cnt_clr) begin
                m_serr = 0;
                m_derr = 0;
            end else begin
                if (hs_s && m_serr != 15) m_serr++;
                if (hs_d && m_derr != 15) m_derr++;
            end
        end
    end

    task automatic send(input logic [39:0] cw, input logic e);
        bit acc;
        acc = 0;
        i_codeword = cw;
        en = e;
        i_valid = 1'b1;
        for (int n = 0; n < 200 && !acc; n++) begin
            @(negedge clk);
            acc = o_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: got no accept, want accept in 200 cycles");
        end
    endtask

    task automatic drain();
        i_valid = 1'b0;
        i_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
    endtask

    function automatic logic [39:0] rand_err(input logic [39:0] cw, input int n);
        logic [39:0] m;
        m = '0;
        while ($countones(m) < n) m[$urandom_range(0, 39)] = 1'b1;
        return cw ^ m;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, want finish before 2ms");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int sv;
        int n0;
        bit done;
        logic [31:0] hold;
        for (int p = 1, c = 0; c < 32; p++) begin
            if ((p & (p - 1)) != 0) begin
                pos_tab[c] = p;
                c++;
            end
        end
        rst_n = 1'b0;
        en = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b1;
        i_codeword = '0;
        i_cnt_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 64'(o_valid), 0);
        chk("rst_flags", 64'({o_serr, o_derr}), 0);
        chk("rst_data", 64'(o_data), 0);
        chk("rst_syn", 64'(o_syndrome), 0);
        chk("rst_cnts", 64'({o_serr_cnt, o_derr_cnt}), 0);
        rst_n = 1'b1;
        #1;
        chk("rst_ready", 64'(o_ready), 1);
        mon_on = 1;

        @(posedge clk);
        #1;
        i_codeword = 40'h0;
        i_valid = 1'b1;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        lat = 1;
        while (!o_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", 64'(lat), 2);
        drain();
        chk("clean_data", 64'(last_data), 0);
        chk("clean_syn", 64'(last_syn), 0);
        chk("clean_flags", 64'({last_serr, last_derr}), 0);

        send(40'h1, 1'b1);
        drain();
        chk("s1_syn", 64'(last_syn), 64'h83);
        chk("s1_data", 64'(last_data), 0);
        chk("s1_serr", 64'(last_serr), 1);
        chk("s1_cnt", 64'(o_serr_cnt), 1);

        send(40'h80_0000_0000, 1'b1);
        drain();
        chk("par_syn", 64'(last_syn), 64'h80);
        chk("par_serr", 64'(last_serr), 1);
        chk("par_data", 64'(last_data), 0);

        send(40'h3, 1'b1);
        drain();
        chk("dbl_derr", 64'(last_derr), 1);
        chk("dbl_syn", 64'(last_syn), 64'h06);
        chk("dbl_data", 64'(last_data), 64'h3);
        chk("dbl_cnt", 64'(o_derr_cnt), 1);

        n0 = n_out;
        fork
            begin
                for (int w = 0; w < 5; w++) begin
                    send(rand_err(encode($urandom), w % 3), 1'b1);
                end
                i_valid = 1'b0;
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                i_ready = 1'b0;
                @(negedge clk);
                hold = o_data;
                chk("bp_valid", 64'(o_valid), 1);
                chk("bp_ready", 64'(o_ready), 0);
                repeat (2) begin
                    @(negedge clk);
                    chk("bp_hold", 64'(o_data), 64'(hold));
                    chk("bp_ready", 64'(o_ready), 0);
                end
                @(posedge clk);
                #1;
                i_ready = 1'b1;
            end
        join
        drain();
        chk("bp_count", 64'(n_out - n0), 5);
        chk("bp_queue", 64'(q.size()), 0);

        sv = m_serr;
        send(40'h1, 1'b0);
        drain();
        chk("byp_data", 64'(last_data), 1);
        chk("byp_flags", 64'({last_serr, last_derr}), 0);
        chk("byp_syn", 64'(last_syn), 0);
        chk("byp_cnt", 64'(o_serr_cnt), 64'(sv));

        for (int w = 0; w < 20; w++) begin
            send(encode($urandom) ^ (40'd1 << $urandom_range(0, 37)), 1'b1);
        end
        drain();
        chk("sat_cnt", 64'(o_serr_cnt), 15);

        send(encode($urandom) ^ 40'h20, 1'b1);
        i_valid = 1'b0;
        for (int n = 0; n < 10 && !o_valid; n++) begin
            @(posedge clk);
            #1;
        end
        i_cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        i_cnt_clr = 1'b0;
        chk("clr_serr", 64'(o_serr_cnt), 0);
        chk("clr_derr", 64'(o_derr_cnt), 0);

        done = 0;
        fork
            begin
                for (int w = 0; w < 300; w++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        i_valid = 1'b0;
                        @(posedge clk);
                        #1;
                    end
                    send(rand_err(encode($urandom), $urandom_range(0, 5) / 2),
                         $urandom_range(0, 9) != 0);
                end
                i_valid = 1'b0;
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    i_ready = $urandom_range(0, 9) < 7;
                    i_cnt_clr = $urandom_range(0, 49) == 0;
                end
            end
        join
        i_cnt_clr = 1'b0;
        drain();
        chk("rand_queue", 64'(q.size()), 0);

        send(rand_err(encode($urandom), 1), 1'b1);
        send(rand_err(encode($urandom), 2), 1'b1);
        #1;
        rst_n = 1'b0;
        i_valid = 1'b0;
        #1;
        q.delete();
        m_serr = 0;
        m_derr = 0;
        chk("mrst_valid", 64'(o_valid), 0);
        chk("mrst_cnts", 64'({o_serr_cnt, o_derr_cnt}), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("mrst_stale", 64'(o_valid), 0);
        end
        send(encode(32'hCAFE_F00D), 1'b1);
        drain();
        chk("mrst_resume", 64'(last_data), 64'hCAFE_F00D);
        chk("mrst_queue", 64'(q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
